// File: rtl/memory_line_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between
// several cache refill/writeback engines. One transaction is in flight at a
// time and each one walks accept -> issue -> wait -> respond.
module memory_line_arbiter #(
    parameter int NUM_REQUESTERS  = 2,
    parameter int LINE_ADDR_WIDTH = 23,
    parameter int LINE_WIDTH      = 100
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_REQUESTERS-1:0]                 req_valid,
    output logic [NUM_REQUESTERS-1:0]                 req_ready,
    input  logic [NUM_REQUESTERS-1:0]                 req_op,
    input  logic [NUM_REQUESTERS*LINE_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQUESTERS*LINE_WIDTH-1:0]      req_data,
    output logic [NUM_REQUESTERS-1:0]                 resp_valid,
    input  logic [NUM_REQUESTERS-1:0]                 resp_ready,
    output logic [LINE_WIDTH-1:0]                     resp_data,
    output logic                                      mem_req_valid,
    input  logic                                      mem_req_ready,
    output logic                                      mem_req_op,
    output logic [LINE_ADDR_WIDTH-1:0]                mem_req_addr,
    output logic [LINE_WIDTH-1:0]                     mem_req_data,
    input  logic                                      mem_resp_valid,
    input  logic [LINE_WIDTH-1:0]                     mem_resp_data,
    output logic [$clog2(NUM_REQUESTERS)-1:0]         grant_id,
    output logic                                      protocol_error
);

    localparam int GW = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    state_t state, state_next;

    logic [GW-1:0]              last_grant;
    logic [GW-1:0]              winner;
    logic                       any_valid;
    logic                       accept;
    logic                       resp_done;
    logic                       op_q;
    logic [LINE_ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0]      data_q;

    logic [LINE_ADDR_WIDTH-1:0] addr_arr [NUM_REQUESTERS];
    logic [LINE_WIDTH-1:0]      data_arr [NUM_REQUESTERS];

    // Unpack the per-requester address and data buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            addr_arr[i] = req_addr[i*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
            data_arr[i] = req_data[i*LINE_WIDTH +: LINE_WIDTH];
        end
    end

    // Round-robin pick: first valid requester after the last one served
    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = last_grant;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
            idx = (32'(last_grant) + k) % NUM_REQUESTERS;
            if (!any_valid && req_valid[GW'(idx)]) begin
                winner    = GW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next    = state;
        req_ready     = '0;
        resp_valid    = '0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        resp_done     = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latches, grant tracking and response data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQUESTERS - 1);
            resp_data  <= '0;
        end else begin
            if (accept) begin
                op_q     <= req_op[winner];
                addr_q   <= addr_arr[winner];
                data_q   <= data_arr[winner];
                grant_id <= winner;
            end
            if (state == WAIT && mem_resp_valid) begin
                resp_data <= op_q ? '0 : mem_resp_data;
            end
            if (resp_done) begin
                last_grant <= grant_id;
            end
        end
    end

    // Sticky flag for memory responses arriving outside WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_error <= 1'b0;
        end else if (mem_resp_valid && state != WAIT) begin
            protocol_error <= 1'b1;
        end
    end

    assign mem_req_op   = op_q;
    assign mem_req_addr = addr_q;
    assign mem_req_data = data_q;

endmodule

// File: tb/tb_memory_line_arbiter.sv
// Self-checking bench for memory_line_arbiter: directed scenarios plus
// randomized transactions checked against a behavioural reference model.
module tb_memory_line_arbiter;

    localparam int N  = 2;
    localparam int AW = 23;
    localparam int LW = 100;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_op;
    logic [N*AW-1:0]  req_addr;
    logic [N*LW-1:0]  req_data;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready;
    logic [LW-1:0]    resp_data;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_op;
    logic [AW-1:0]    mem_req_addr;
    logic [LW-1:0]    mem_req_data;
    logic             mem_resp_valid;
    logic [LW-1:0]    mem_resp_data;
    logic [0:0]       grant_id;
    logic             protocol_error;

    memory_line_arbiter #(
        .NUM_REQUESTERS (N),
        .LINE_ADDR_WIDTH(AW),
        .LINE_WIDTH     (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_op    (mem_req_op),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .grant_id      (grant_id),
        .protocol_error(protocol_error)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            last_grant;
    logic          exp_perr;
    logic          r_op   [N];
    logic [AW-1:0] r_addr [N];
    logic [LW-1:0] r_data [N];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scan order: the requester after the last served one comes first
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last_grant + k) % N]) return (last_grant + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[LW-1:0];
    endfunction

    task automatic drive_requests(input logic [N-1:0] vmask);
        req_valid = vmask;
        for (int i = 0; i < N; i++) begin
            req_op[i]             = r_op[i];
            req_addr[i*AW +: AW]  = r_addr[i];
            req_data[i*LW +: LW]  = r_data[i];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"},  resp_data, 0);
        check({tag, "_mem_valid"},  mem_req_valid, 0);
        check({tag, "_mem_op"},     mem_req_op, 0);
        check({tag, "_mem_addr"},   mem_req_addr, 0);
        check({tag, "_mem_data"},   mem_req_data, 0);
        check({tag, "_grant_id"},   grant_id, 0);
        check({tag, "_perr"},       protocol_error, 0);
    endtask

    // One full transaction with the bench acting as memory
    task automatic do_txn(input logic [N-1:0] vmask, input int stall_req, input int mem_lat,
                          input int stall_resp, input logic [LW-1:0] mem_line);
        int            w;
        logic [N-1:0]  exp_ready;
        logic [LW-1:0] exp_data;
        @(negedge clk);
        drive_requests(vmask);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        resp_ready     = '0;
        #1;
        w         = pick(vmask);
        exp_ready = N'(1) << w;
        check("idle_req_ready", req_ready, exp_ready);
        check("idle_mem_valid", mem_req_valid, 0);
        for (int i = 0; i <= stall_req; i++) begin
            @(negedge clk);
            mem_req_ready = (i == stall_req);
            #1;
            if (i == 0) check("grant_id", grant_id, w);
            check("issue_mem_valid", mem_req_valid, 1);
            check("issue_req_ready", req_ready, 0);
            check("issue_op",   mem_req_op, r_op[w]);
            check("issue_addr", mem_req_addr, r_addr[w]);
            check("issue_data", mem_req_data, r_data[w]);
        end
        for (int i = 0; i <= mem_lat; i++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = (i == mem_lat);
            mem_resp_data  = (i == mem_lat) ? mem_line : rand_line();
            #1;
            check("wait_mem_valid", mem_req_valid, 0);
            check("wait_resp_valid", resp_valid, 0);
        end
        exp_data = r_op[w] ? '0 : mem_line;
        for (int i = 0; i <= stall_resp; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_data  = rand_line();
            resp_ready     = (i == stall_resp) ? exp_ready : ~exp_ready;
            #1;
            check("resp_valid", resp_valid, exp_ready);
            check("resp_data", resp_data, exp_data);
            check("resp_req_ready", req_ready, 0);
        end
        last_grant = w;
        @(negedge clk);
        resp_ready = '0;
        req_valid  = '0;
        #1;
        check("post_resp_valid", resp_valid, 0);
        check("post_grant_hold", grant_id, w);
        check("post_perr", protocol_error, exp_perr);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_op         = '0;
        req_addr       = '0;
        req_data       = '0;
        resp_ready     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        last_grant     = N - 1;
        exp_perr       = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_op[i]   = 1'b0;
            r_addr[i] = AW'($urandom);
            r_data[i] = rand_line();
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sustained requests from both: strict alternation starting at 0
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin
                r_op[i]   = 1'($urandom);
                r_addr[i] = AW'($urandom);
                r_data[i] = rand_line();
            end
            do_txn(2'b11, 0, 0, 0, rand_line());
            check("rr_sequence", grant_id, t % 2);
        end

        // LOAD with a 5-cycle memory stall and an all-ones fill line
        r_op[0]   = 1'b0;
        r_addr[0] = 23'h1ABCD;
        r_data[0] = rand_line();
        do_txn(2'b01, 5, 1, 0, {LW{1'b1}});

        // STORE: ack must return zero data even though memory drives garbage
        r_op[1]   = 1'b1;
        r_data[1] = 100'h123;
        r_addr[1] = AW'($urandom);
        do_txn(2'b10, 0, 2, 0, rand_line());

        // Requester holds off resp_ready for 3 cycles while both keep requesting
        r_op[0] = 1'b0;
        r_op[1] = 1'b0;
        do_txn(2'b11, 1, 0, 3, rand_line());

        // Randomized traffic
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                r_op[i]   = 1'($urandom);
                r_addr[i] = AW'($urandom);
                r_data[i] = rand_line();
            end
            do_txn(N'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), rand_line());
        end

        // Stray memory response in IDLE sets the sticky error
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = rand_line();
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        exp_perr = 1'b1;
        check("perr_set", protocol_error, 1);
        r_op[0]   = 1'b0;
        r_addr[0] = AW'($urandom);
        do_txn(2'b01, 0, 0, 0, {LW{1'b1}});

        // Reset while waiting on memory abandons the transaction
        @(negedge clk);
        r_op[1] = 1'b1;
        drive_requests(2'b10);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("midwait_mem_valid", mem_req_valid, 0);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        @(negedge clk);
        rst_n      = 1'b1;
        last_grant = N - 1;
        exp_perr   = 1'b0;
        for (int i = 0; i < N; i++) r_op[i] = 1'b0;
        do_txn(2'b11, 0, 0, 0, rand_line());
        check("after_reset_grant0", grant_id, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
